// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin owner selection for one shared interval counter.
// The winner's duration is latched, the counter is cleared, counts up to the
// duration, and a one-cycle done pulse is returned to the owner.
module timer_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned CNT_BITS = 4
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*CNT_BITS-1:0]  dur,
  input  logic                         abort,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic                         busy,
  output logic [CNT_BITS-1:0]          cur_count
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_n;
  logic [IDX_W-1:0]     idx_q, idx_n;
  logic [IDX_W-1:0]     last_q, last_n;
  logic [CNT_BITS-1:0]  dur_q, dur_n;
  logic [NUM_REQ-1:0]   grant_n, done_n;
  logic                 busy_n;

  logic                 cnt_clear;
  logic                 cnt_enable;
  logic                 cnt_wrap;
  logic                 cnt_at_max;

  logic [CNT_BITS-1:0]  dur_arr [NUM_REQ];
  logic [IDX_W-1:0]     cand;
  logic [IDX_W-1:0]     win;
  logic                 found;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Per-requester view of the packed duration bus
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_dur
    assign dur_arr[g] = dur[g*CNT_BITS +: CNT_BITS];
  end

  // Shared counter: clear beats enable, saturates at max when not wrapping
  assign cnt_wrap   = 1'b0;
  assign cnt_at_max = (cur_count == dur_q);

  // Counter register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cur_count <= '0;
    end else if (cnt_clear) begin
      cur_count <= '0;
    end else if (cnt_enable) begin
      if (cnt_at_max) begin
        if (cnt_wrap) cur_count <= '0;
      end else begin
        cur_count <= cur_count + CNT_BITS'(1);
      end
    end
  end

  // Round-robin search starting just after the last owner
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((32'(last_q) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Next-state, counter control and next registered outputs
  always_comb begin
    state_n    = state_q;
    idx_n      = idx_q;
    dur_n      = dur_q;
    last_n     = last_q;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_n = S_LOAD;
          idx_n   = win;
          dur_n   = dur_arr[win];
        end
      end
      S_LOAD: begin
        cnt_clear = 1'b1;
        if (abort) begin
          state_n = S_IDLE;
          last_n  = idx_q;
        end else begin
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          cnt_clear = 1'b1;
          state_n   = S_IDLE;
          last_n    = idx_q;
        end else begin
          cnt_enable = !cnt_at_max;
          if (cnt_at_max) state_n = S_DONE;
        end
      end
      S_DONE: begin
        last_n  = idx_q;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    busy_n  = (state_n != S_IDLE);
    grant_n = busy_n ? onehot(idx_n) : '0;
    done_n  = (state_n == S_DONE) ? onehot(idx_n) : '0;
  end

  // State and output registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      dur_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      grant   <= '0;
      done    <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      dur_q   <= dur_n;
      last_q  <= last_n;
      grant   <= grant_n;
      done    <= done_n;
      busy    <= busy_n;
    end
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: interval-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_timer_arbiter;

  localparam int N  = 4;
  localparam int CB = 4;

  logic            tb_clk = 1'b0;
  logic            nrst;
  logic [N-1:0]    req;
  logic [N*CB-1:0] dur;
  logic            abort;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic            busy;
  logic [CB-1:0]   cur_count;

  int total = 0;
  int bad   = 0;

  // Model: one interval described by its start edge offset t and length d
  bit m_active;
  int m_t, m_d, m_idx, m_last, m_held;

  timer_arbiter #(.NUM_REQ(N), .CNT_BITS(CB)) dut (
    .clk(tb_clk), .nrst(nrst), .req(req), .dur(dur), .abort(abort),
    .grant(grant), .done(done), .busy(busy), .cur_count(cur_count)
  );

  always #5 tb_clk = ~tb_clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_active = 1'b0;
    m_t = 0; m_d = 0; m_idx = 0;
    m_last = N - 1;
    m_held = 0;
  endfunction

  // Advance the model by one rising edge using the inputs seen at that edge
  function automatic void model_edge();
    if (!nrst) begin
      model_reset();
      return;
    end
    if (m_active) begin
      if (abort && m_t <= m_d + 1) begin
        m_active = 1'b0;
        m_last   = m_idx;
        m_held   = 0;
      end else begin
        m_t++;
        if (m_t == m_d + 3) begin
          m_active = 1'b0;
          m_last   = m_idx;
          m_held   = m_d;
        end
      end
    end else if (req != '0) begin
      for (int i = 1; i <= N; i++) begin
        int c;
        c = (m_last + i) % N;
        if (req[c]) begin
          m_idx = c;
          break;
        end
      end
      m_d      = int'(dur[m_idx*CB +: CB]);
      m_active = 1'b1;
      m_t      = 0;
    end
  endfunction

  task automatic compare_all();
    logic [N-1:0] eg, ed;
    int ec;
    eg = m_active ? (N'(1) << m_idx) : '0;
    ed = (m_active && m_t == m_d + 2) ? (N'(1) << m_idx) : '0;
    if (m_active && m_t >= 1) ec = (m_t - 1 < m_d) ? m_t - 1 : m_d;
    else ec = m_held;
    check("grant", int'(grant), int'(eg));
    check("done", int'(done), int'(ed));
    check("busy", int'(busy), int'(m_active));
    check("cur_count", int'(cur_count), ec);
  endtask

  task automatic step();
    @(posedge tb_clk);
    model_edge();
    @(negedge tb_clk);
    compare_all();
  endtask

  task automatic apply_reset();
    nrst = 1'b0; req = '0; abort = 1'b0;
    step();
    nrst = 1'b1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) step();
    check("wait_idle", int'(busy), 0);
  endtask

  initial begin
    int cnt_g, cnt_d, n_rise;
    int exp_order [5];
    logic [N-1:0] prev_g;
    exp_order = '{0, 1, 2, 3, 0};
    model_reset();

    // Reset held with all requests asserted
    nrst = 1'b0; req = 4'b1111; dur = '0; abort = 1'b0;
    step(); step();
    check("rst_grant", int'(grant), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_count", int'(cur_count), 0);
    nrst = 1'b1;
    step();
    check("first_grant", int'(grant), 4'b0001);
    req = '0;
    wait_idle();

    // Single request, duration 5
    apply_reset();
    req = 4'b0010; dur = 16'h0050;
    step();
    req = '0;
    cnt_g = (grant == 4'b0010) ? 1 : 0;
    cnt_d = 0;
    for (int i = 0; i < 11; i++) begin
      step();
      if (grant == 4'b0010) cnt_g++;
      if (done != '0) begin
        cnt_d++;
        check("single_done_val", int'(done), 4'b0010);
        check("single_done_cnt", int'(cur_count), 5);
      end
    end
    check("single_grant_len", cnt_g, 8);
    check("single_done_len", cnt_d, 1);

    // Round-robin fairness, all durations 2
    apply_reset();
    req = 4'b1111; dur = 16'h2222;
    prev_g = '0; n_rise = 0;
    for (int i = 0; i < 26; i++) begin
      step();
      if (grant != '0 && prev_g == '0 && n_rise < 5) begin
        for (int b = 0; b < N; b++)
          if (grant[b]) check("rr_order", b, exp_order[n_rise]);
        n_rise++;
      end
      prev_g = grant;
    end
    check("rr_grants", n_rise, 5);
    req = '0;
    wait_idle();

    // Zero duration
    apply_reset();
    req = 4'b0100; dur = 16'h0000;
    step();
    req = '0;
    cnt_g = (grant == 4'b0100) ? 1 : 0;
    cnt_d = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (grant == 4'b0100) cnt_g++;
      if (done == 4'b0100) cnt_d++;
      check("zero_count", int'(cur_count), 0);
    end
    check("zero_grant_len", cnt_g, 3);
    check("zero_done_len", cnt_d, 1);

    // Abort mid-run; next grant goes to requester 1
    apply_reset();
    req = 4'b0011; dur = 16'h0009;
    for (int i = 0; i < 20 && cur_count != 4'd3; i++) step();
    check("abort_reach3", int'(cur_count), 3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_grant", int'(grant), 0);
    check("abort_count", int'(cur_count), 0);
    step();
    check("abort_next", int'(grant), 4'b0010);
    req = '0;
    wait_idle();

    // Asynchronous reset mid-run
    apply_reset();
    req = 4'b0001; dur = 16'h0009;
    for (int i = 0; i < 20 && cur_count != 4'd6; i++) step();
    check("arst_reach6", int'(cur_count), 6);
    #2 nrst = 1'b0;
    #1;
    model_reset();
    check("arst_grant", int'(grant), 0);
    check("arst_done", int'(done), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_count", int'(cur_count), 0);
    step();
    nrst = 1'b1; req = 4'b1000;
    step();
    check("arst_regrant", int'(grant), 4'b1000);
    step();
    check("arst_count0", int'(cur_count), 0);
    req = '0;
    wait_idle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      req   = N'($urandom_range(0, 15));
      dur   = (N*CB)'($urandom);
      abort = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/timer_arbiter.md
# timer_arbiter

Round-robin controller that shares one instance of the team's `counter` block among `NUM_REQ` requesters, each asking for a timed interval of its own length. The block arbitrates among the requests and loads the winner's duration into the counter's `max` input. It then sequences the counter through clear → count → terminal and returns a one-cycle completion pulse to the winner. It sits between client FSMs that need delays and the single shared timing resource.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; must be ≥ 2.
- `CNT_BITS`, 4: counter width; passed to the internal `counter` as `NUM_BITS`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  level request per requester; sampled only in IDLE.
- `dur`  in  NUM_REQ*CNT_BITS  requested duration; requester i uses `dur[i*CNT_BITS +: CNT_BITS]`.
- `abort`  in  1  cancels the current interval; effective in LOAD and RUN only.
- `grant`  out  NUM_REQ  one-hot owner of the timer; all zero when idle.
- `done`  out  NUM_REQ  one-cycle completion pulse to the owner.
- `busy`  out  1  high whenever the state is not IDLE.
- `cur_count`  out  CNT_BITS  live count value of the internal counter.

## Operation
- Internal `counter` instance:
  - `wrap` is tied to 0.
  - `max` is driven from the latched duration register `dur_q`.
  - `clear` is driven by the FSM; `clear` has priority over `enable` inside the counter.
  - `at_max` is true when `count == max`.
  - With `wrap = 0`, the counter holds its value at `max`.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If `req != 0`, select the winner by round-robin: search from index `last+1` upward, modulo `NUM_REQ`.
  - Latch the winner index into `idx_q` and its `dur` slice into `dur_q`, then go to LOAD.
  - If `req == 0`, stay in IDLE.
- LOAD:
  - Assert `clear` for exactly one cycle, then go to RUN.
  - If `abort = 1`, go to IDLE instead.
- RUN:
  - Drive `enable = !at_max`.
  - If `at_max = 1`, go to DONE.
  - `abort` has priority over `at_max`: if `abort = 1`, assert `clear` and go to IDLE.
- DONE:
  - Assert `done[idx_q]` for exactly one cycle.
  - Set `last = idx_q`, then go to IDLE.
- Outputs by state:
  - `grant[idx_q]` is high in LOAD, RUN and DONE.
  - `grant` and `done` are zero in IDLE.
  - `done` is only ever high in DONE.
- Abort: no `done` pulse is issued, and `last` is still updated to `idx_q`, so the aborted requester loses its turn.
- Duration latching:
  - `dur` and `req` changes while busy are ignored.
  - Dropping `req` mid-interval does not cancel the interval; only `abort` does.
- Duration arithmetic:
  - The interval spans `cur_count` values 0 through `dur_q` inclusive; all values are unsigned.
  - `dur = 0` is legal: RUN lasts one cycle.
  - `dur = 2^CNT_BITS-1` is legal and requires no overflow handling, because the counter does not wrap.
- Reset values, applied asynchronously while `nrst = 0`:
  - state = IDLE
  - `grant = 0`, `done = 0`, `busy = 0`
  - `cur_count = 0`
  - `dur_q = 0`, `idx_q = 0`
  - `last = NUM_REQ-1`, so requester 0 has highest priority after reset.
- Reset mid-interval: the interval is abandoned immediately, with no `done` pulse.

## Timing
Cycle numbering for one interval, where the winner is sampled at edge k and `d = dur_q`:
- Edge k: state becomes LOAD and `grant` rises.
- Edge k+1: count = 0, state becomes RUN.
- Edges k+2 … k+1+d: count increments by 1 per edge and reaches d after edge k+1+d.
- Edge k+2+d: state becomes DONE and `done` goes high.
- Edge k+3+d: state becomes IDLE; `grant` and `done` fall.
- `grant` is high for exactly d+3 cycles; `done` is high for 1 cycle.

Further timing rules:
- A minimum of one IDLE cycle separates consecutive grants; the next winner is sampled at edge k+4+d.
- `abort` is sampled at the rising edge: after the edge where it is seen, `grant = 0`, `busy = 0`, and count = 0.
- Arbitration latency from `req` rising (with the block idle) to `grant` rising is 1 edge.
- `cur_count` holds at d during the DONE cycle and returns to 0 at the next LOAD.

## Test plan
- **Reset:** hold `nrst = 0` with `req = 4'b1111` for 2 cycles → `grant = 0`, `done = 0`, `busy = 0`, `cur_count = 0`. After release, the first edge gives `grant = 4'b0001`.
- **Single request:** `req = 4'b0010`, `dur1 = 5` → `grant = 4'b0010` for 8 cycles. `cur_count` steps 0,1,2,3,4,5, then holds at 5 during the cycle where `done = 4'b0010` for exactly 1 cycle. `busy` falls on the next edge.
- **Round-robin fairness:** `req = 4'b1111` held, all `dur = 2` → grant order 0,1,2,3,0. Each grant lasts 5 cycles, with 1 idle cycle between grants.
- **Zero duration:** `req = 4'b0100`, `dur2 = 0` → grant for 3 cycles, `cur_count = 0` throughout, one `done[2]` pulse.
- **Abort:** `req = 4'b0011`, `dur0 = 9`; assert `abort` when `cur_count = 3` → next edge gives `grant = 0`, `cur_count = 0`, and no `done` pulse. The following grant goes to requester 1.
- **Asynchronous reset mid-interval:** drop `nrst` mid-RUN at `cur_count = 6` → all outputs go to 0 without waiting for an edge. After release, with `req = 4'b1000`, the grant goes to requester 3 and `cur_count` counts from 0.
